// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci index finder: FSM state encoding
// and the default datapath widths for the 28-bit lab configuration.
package fibo_pkg;

    // Controller states: waiting for a request, or walking the sequence
    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    // Default width of the value being inverted
    localparam int DEFAULT_WIDTH = 28;

    // Default width of the index output; must hold MAX_IDX
    localparam int DEFAULT_IDX_W = 6;

    // Largest index n with F(n) < 2^28, i.e. F(42) = 267914296
    localparam int MAX_IDX = 42;

endpackage

// File: rtl/fibonacci_index_finder.sv
// Fibonacci index finder: for a latched value, walks the sequence
// F(0)=0, F(1)=1, ... one term per cycle until F(n+1) exceeds the value,
// then reports n, F(n), value - F(n) and whether value is exactly F(n).
// Ties resolve to the largest index (value 1 gives n=2) because the walk
// only stops once the *next* term is strictly greater than the value.
module fibonacci_index_finder
    import fibo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_in,
    input  logic             start,
    output logic [IDX_W-1:0] index_out,
    output logic [WIDTH-1:0] fib_floor,
    output logic [WIDTH-1:0] remainder,
    output logic             exact,
    output logic             done,
    output logic             busy
);

    state_t state;
    state_t next_state;

    // a holds F(n), b holds F(n+1). Both carry one extra bit because
    // F(n+1) may exceed the largest WIDTH-bit value (F(43) for WIDTH=28).
    logic [WIDTH-1:0] value_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   b_q;
    logic [IDX_W-1:0] n_q;

    logic [WIDTH:0]   value_ext;
    logic             load;
    logic             finish;

    assign value_ext = {1'b0, value_q};
    assign busy      = (state == SEARCH);

    // State register; reset aborts any search in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the load/finish strobes that steer the datapath
    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SEARCH;
                end
            end
            SEARCH: begin
                if (b_q > value_ext) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Search datapath: seed the sequence on start, then advance one term per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
        end else if (load) begin
            value_q <= value_in;
            a_q     <= '0;
            b_q     <= {{WIDTH{1'b0}}, 1'b1};
            n_q     <= '0;
        end else if ((state == SEARCH) && !finish) begin
            a_q     <= b_q;
            b_q     <= a_q + b_q;
            n_q     <= n_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    // Result registers: capture on finish and hold until the next finish
    always_ff @(posedge clk) begin
        if (reset) begin
            index_out <= '0;
            fib_floor <= '0;
            remainder <= '0;
            exact     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                index_out <= n_q;
                fib_floor <= a_q[WIDTH-1:0];
                remainder <= value_q - a_q[WIDTH-1:0];
                exact     <= (a_q == value_ext);
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// Self-checking bench for fibonacci_index_finder: a table of directed
// values with hand-computed index/floor/remainder/latency, followed by
// hand-written sequences for busy-ignore, back-to-back start and reset abort.
module tb_fibonacci_index_finder;

    localparam int WIDTH = 28;
    localparam int IDX_W = 6;
    localparam int TIMEOUT = 100;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] value_in;
    logic             start;
    logic [IDX_W-1:0] index_out;
    logic [WIDTH-1:0] fib_floor;
    logic [WIDTH-1:0] remainder;
    logic             exact;
    logic             done;
    logic             busy;

    int checks;
    int errors;

    typedef struct {
        logic [WIDTH-1:0] value;
        int               exp_idx;
        int               exp_floor;
        int               exp_rem;
        int               exp_exact;
        int               exp_lat;
    } vector_t;

    vector_t vectors[8];

    fibonacci_index_finder #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value_in  (value_in),
        .start     (start),
        .index_out (index_out),
        .fib_floor (fib_floor),
        .remainder (remainder),
        .exact     (exact),
        .done      (done),
        .busy      (busy)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Wait for done, counting edges after the start edge; returns latency
    task automatic waitDone(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Present a start pulse from just after an edge, then wait for done
    task automatic applyStimulus(input logic [WIDTH-1:0] v, output int lat);
        value_in = v;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat);
    endtask

    task automatic checkResult(input string tag, input int lat, input vector_t e);
        checkOutput({tag, " latency"}, lat, e.exp_lat);
        checkOutput({tag, " done"}, done, 1);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " index"}, index_out, e.exp_idx);
        checkOutput({tag, " fib_floor"}, fib_floor, e.exp_floor);
        checkOutput({tag, " remainder"}, remainder, e.exp_rem);
        checkOutput({tag, " exact"}, exact, e.exp_exact);
    endtask

    initial begin
        int      lat;
        vector_t e;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        value_in = '0;

        vectors[0] = '{28'd0,         0,  0,         0,      1, 1};
        vectors[1] = '{28'd1,         2,  1,         0,      1, 3};
        vectors[2] = '{28'd2,         3,  2,         0,      1, 4};
        vectors[3] = '{28'd4,         4,  3,         1,      0, 5};
        vectors[4] = '{28'd100,       11, 89,        11,     0, 12};
        vectors[5] = '{28'd143,       11, 89,        54,     0, 12};
        vectors[6] = '{28'd268435455, 42, 267914296, 521159, 0, 43};
        vectors[7] = '{28'd267914296, 42, 267914296, 0,      1, 43};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("reset index", index_out, 0);
        checkOutput("reset fib_floor", fib_floor, 0);
        checkOutput("reset remainder", remainder, 0);
        checkOutput("reset exact", exact, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].value, lat);
            checkResult($sformatf("vec%0d", i), lat, vectors[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done pulse", i), done, 0);
            checkOutput($sformatf("vec%0d hold index", i), index_out, vectors[i].exp_idx);
            checkOutput($sformatf("vec%0d hold floor", i), fib_floor, vectors[i].exp_floor);
        end

        // Start 100, then hammer start with 5 while busy: must be ignored
        value_in = 28'd100;
        start    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busy after start", busy, 1);
        value_in = 28'd5;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        waitDone(lat);
        e = '{28'd100, 11, 89, 11, 0, 9};
        checkResult("busy-ignore", lat, e);

        // Start issued in the done cycle is accepted
        applyStimulus(28'd5, lat);
        e = '{28'd5, 5, 5, 0, 1, 6};
        checkResult("back-to-back", lat, e);

        // Reset in the middle of a long search: no done, outputs cleared
        value_in = 28'd268435455;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort index", index_out, 0);
        checkOutput("abort fib_floor", fib_floor, 0);
        checkOutput("abort remainder", remainder, 0);
        checkOutput("abort exact", exact, 0);
        checkOutput("abort busy", busy, 0);
        waitDone(lat);
        checkOutput("abort no done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
